// File: rtl/nr_div_reconstructor.sv
// Sequential shift-add reconstructor: rebuilds P = Q*D + R (mod 2^OW) over QW cycles.
// Optional range check on the accepted operands is enabled by defining NR_RECON_CHECK_EN.
module nr_div_reconstructor #(
  parameter int QW = 3,
  parameter int DW = 2,
  parameter int RW = 5,
  parameter int OW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [QW-1:0] Q,
  input  logic [DW-1:0] D,
  input  logic [RW-1:0] R,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] P,
  output logic          chk_err
);

  localparam int CW = (QW > 1) ? $clog2(QW) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [QW-1:0] q_sh_q, q_sh_d;
  logic [OW-1:0] d_sh_q, d_sh_d;
  logic [OW-1:0] acc_q, acc_d;
  logic [OW-1:0] p_q, p_d;
  logic [OW-1:0] acc_sum;
  logic          accept;
  logic          deliver;

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign P         = p_q;
  assign accept    = in_valid && in_ready;
  assign deliver   = out_valid && out_ready;
  assign acc_sum   = acc_q + (q_sh_q[0] ? d_sh_q : '0);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    state_d = state_q;
    cnt_d   = cnt_q;
    q_sh_d  = q_sh_q;
    d_sh_d  = d_sh_q;
    acc_d   = acc_q;
    p_d     = p_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          q_sh_d  = Q;
          d_sh_d  = OW'(D);
          acc_d   = OW'(R);
          cnt_d   = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        acc_d  = acc_sum;
        d_sh_d = d_sh_q << 1;
        q_sh_d = q_sh_q >> 1;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(QW - 1)) begin
          p_d     = acc_sum;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (deliver) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      q_sh_q  <= '0;
      d_sh_q  <= '0;
      acc_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_sh_q  <= q_sh_d;
      d_sh_q  <= d_sh_d;
      acc_q   <= acc_d;
      p_q     <= p_d;
    end
  end

`ifdef NR_RECON_CHECK_EN
  localparam int CMPW = (RW > DW) ? RW : DW;
  logic chk_q;

  // Flags a remainder that no completed division could have produced.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chk_q <= 1'b0;
    end else if (accept) begin
      chk_q <= (D == '0) || (CMPW'(R) >= CMPW'(D));
    end else if (deliver) begin
      chk_q <= 1'b0;
    end
  end

  assign chk_err = chk_q;
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_nr_div_reconstructor.sv
// Self-checking bench for nr_div_reconstructor: directed cases with literal results
// plus randomized traffic compared every cycle against a transaction-level model.
module tb_nr_div_reconstructor;

  localparam int QW = 3;
  localparam int DW = 2;
  localparam int RW = 5;
  localparam int OW = 6;
`ifdef NR_RECON_CHECK_EN
  localparam int CHK_EN = 1;
`else
  localparam int CHK_EN = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b1;
  logic [QW-1:0] Q = '0;
  logic [DW-1:0] D = '0;
  logic [RW-1:0] R = '0;
  logic          in_ready;
  logic          out_valid;
  logic [OW-1:0] P;
  logic          chk_err;

  int n_vec = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  nr_div_reconstructor #(.QW(QW), .DW(DW), .RW(RW), .OW(OW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Q         (Q),
    .D         (D),
    .R         (R),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .P         (P),
    .chk_err   (chk_err)
  );

  task automatic check(input string name, input int actual, input int expected);
    n_vec++;
    if (actual != expected) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Transaction-level model: busy flag plus edges elapsed since acceptance.
  bit m_busy   = 1'b0;
  int m_age    = 0;
  int m_p      = 0;
  int m_pend_p = 0;
  bit m_chk    = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b0;
      m_age  = 0;
      m_p    = 0;
      m_chk  = 1'b0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy   = 1'b1;
        m_age    = 0;
        m_pend_p = (int'(Q) * int'(D) + int'(R)) % (1 << OW);
        m_chk    = (CHK_EN != 0) && (int'(D) == 0 || int'(R) >= int'(D));
      end
    end else if (m_age < QW) begin
      m_age++;
      if (m_age == QW) m_p = m_pend_p;
    end else if (out_ready) begin
      m_busy = 1'b0;
      m_chk  = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("in_ready", int'(in_ready), int'(!m_busy));
      check("out_valid", int'(out_valid), int'(m_busy && m_age == QW));
      check("chk_err", int'(chk_err), int'(m_chk));
      if (m_busy && m_age == QW) check("P", int'(P), m_p);
    end
  end

  task automatic run_txn(input int q, input int d, input int r,
                         input int exp_p, input int exp_chk, input string tag);
    int lat;
    @(posedge clk); #1;
    in_valid = 1'b1;
    Q = QW'(q);
    D = DW'(d);
    R = RW'(r);
    @(posedge clk); #1;
    in_valid = 1'b0;
    Q = QW'($urandom);
    D = DW'($urandom);
    R = RW'($urandom);
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_valid) break;
    end
    check({tag, "_latency"}, lat, 3);
    check({tag, "_P"}, int'(P), exp_p);
    check({tag, "_chk_err"}, int'(chk_err), exp_chk);
    @(posedge clk); #1;
  endtask

  initial begin
    int last_rise;
    bit prev_ov;
    #1 chk_on = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_P", int'(P), 0);
    check("rst_chk_err", int'(chk_err), 0);

    run_txn(5, 3, 2, 17, 0, "t1");
    run_txn(7, 3, 31, 52, CHK_EN, "t2");
    run_txn(4, 0, 1, 1, CHK_EN, "t3");

    // Consumer stalls for five cycles while new operands are offered.
    out_ready = 1'b0;
    run_txn(6, 3, 4, 22, CHK_EN, "t4");
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      Q = QW'($urandom);
      D = DW'($urandom);
      R = RW'($urandom);
      @(negedge clk);
      check("t4_P_hold", int'(P), 22);
      check("t4_out_valid_hold", int'(out_valid), 1);
      check("t4_in_ready_low", int'(in_ready), 0);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;

    // Reset lands in the second CALC cycle.
    @(posedge clk); #1;
    in_valid = 1'b1;
    Q = 3'd6;
    D = 2'd3;
    R = 5'd9;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #2 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t5_no_out_valid", int'(out_valid), 0);
      check("t5_in_ready", int'(in_ready), 1);
      check("t5_P_cleared", int'(P), 0);
    end
    @(posedge clk); #1;
    run_txn(2, 2, 1, 5, 0, "t5b");

    // Back-to-back operands with an always-ready consumer.
    last_rise = -1;
    prev_ov   = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      Q = QW'($urandom);
      D = DW'($urandom);
      R = RW'($urandom);
      @(negedge clk);
      if (out_valid && !prev_ov) begin
        if (last_rise >= 0) check("t6_spacing", cyc - last_rise, 5);
        last_rise = cyc;
      end
      prev_ov = out_valid;
    end
    check("t6_seen", int'(last_rise >= 0), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;

    // Randomized traffic, back-pressure and occasional asynchronous resets.
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      Q = QW'($urandom);
      D = DW'($urandom);
      R = RW'($urandom);
      if ($urandom_range(0, 120) == 0) begin
        rst = 1'b1;
        #2 rst = 1'b0;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
